// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the ALU arbiter: FSM state encoding,
// default parameters and the pointer-width helper.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_OP_W    = 4;
    localparam int DEF_TIMEOUT = 16;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins; outputs a one-hot grant and the winner index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx
);

    logic found;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && ((int'(ptr) + k) % NUM_REQ) == i) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin accept, one-cycle
// launch, watchdog-guarded wait for alu_done, per-owner response handshake.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OP_W    = DEF_OP_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     resp_err,
    output logic                     alu_start,
    output logic [OP_W-1:0]          alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic                     alu_done,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     busy
);

    localparam int PTR_W = ptr_w(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [WD_W-1:0]    wd_cnt;
    logic [WIDTH-1:0]   data;
    logic               err;
    logic               resp_fire;
    logic [OP_W-1:0]    sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req  (req_valid),
        .ptr  (ptr),
        .grant(grant),
        .idx  (win_idx)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);
    assign resp_data = data;
    assign resp_err  = err;
    assign resp_fire = |(resp_valid & resp_ready);
    assign next_ptr  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

    // Operand mux driven by the one-hot grant, so no variable part-selects are needed.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i*OP_W +: OP_W];
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state == RESP && owner == PTR_W'(i)) resp_valid[i] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            wd_cnt    <= '0;
            data      <= '0;
            err       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        owner     <= win_idx;
                        alu_op    <= sel_op;
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    // A result arriving on the last watchdog cycle still counts as success.
                    if (alu_done) begin
                        data  <= alu_result;
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        data  <= '0;
                        err   <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU datapath between NUM_REQ independent requesters. Each requester issues an opcode and two operands through a valid/ready handshake. The arbiter picks one requester round-robin, sequences the ALU through a start/done handshake, guards against a hung ALU with a timeout watchdog, and returns the result to the owner through a per-requester valid/ready response. It sits between the requester clients and the ALU core that `interface_alu` exposes.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, ALU operand/result width
- OP_W, 4, opcode width
- TIMEOUT, 16, max cycles waited for alu_done (≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  grant/accept, one-hot or zero
- req_op  in  NUM_REQ*OP_W  packed opcodes; requester i at [i*OP_W +: OP_W]
- req_a, req_b  in  NUM_REQ*WIDTH  packed operands, same indexing
- resp_valid  out  NUM_REQ  response available, one-hot or zero
- resp_ready  in  NUM_REQ  response consumed
- resp_data  out  WIDTH  result, shared by all requesters
- resp_err  out  1  response is a timeout; resp_data=0
- alu_start  out  1  one-cycle ALU launch pulse
- alu_op  out  OP_W  registered opcode to ALU
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_done  in  1  ALU result valid this cycle
- alu_result  in  WIDTH  ALU result
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, assert req_ready for the rr winner, combinationally. The accept cycle is req_valid&req_ready. In that cycle, register owner, op, a, b, then go to ISSUE. No req_valid: stay in IDLE, req_ready=0.
- Round robin: priority order is ptr, ptr+1, … wrapping mod NUM_REQ. ptr resets to 0. ptr ← owner+1 (wrap) when the response completes.
- ISSUE: alu_start=1 for exactly one cycle, wd_cnt←0, go to WAIT. alu_done is ignored in ISSUE.
- WAIT: wd_cnt increments each cycle.
  - If alu_done: capture alu_result, err←0, go to RESP.
  - Else if wd_cnt==TIMEOUT-1: data←0, err←1, go to RESP.
  - alu_done wins over timeout in the same cycle.
- RESP: resp_valid[owner]=1 with resp_data/resp_err stable. When resp_ready[owner]=1, update ptr and go to IDLE. resp_ready on other bits is ignored.
- alu_done outside WAIT is ignored; no state or data change.
- alu_op/alu_a/alu_b hold their captured values from ISSUE until the next accept.
- Requests never reorder within a requester. A requester has at most one op in flight.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, alu_start=0, alu_op/alu_a/alu_b=0, busy=0, ptr=0, state=IDLE.
- Reset mid-operation: the in-flight op is discarded, no response is issued, and the block is in IDLE the next cycle.
- Request accepted at cycle t → alu_start at t+1 → alu_done sampled from t+2 → resp_valid the cycle after done.
- Minimum per-op occupancy: 4 cycles (accept, issue, done, resp with resp_ready=1).
- Timeout: with no alu_done, resp_err rises TIMEOUT+1 cycles after alu_start.
- The next accept occurs no earlier than the cycle after the response handshake; IDLE does not overlap RESP.
- Requesters must hold req_valid/req_op/req_a/req_b stable until accepted.

## Structure
- Package alu_arb_pkg:
  - state_t enum (IDLE, ISSUE, WAIT, RESP)
  - default parameter constants
  - function clog2-based PTR_W
- Sub-module rr_arbiter: combinational. Inputs are the req vector and ptr; outputs are a one-hot grant and the winner index. It is instantiated once inside alu_arbiter.
- Watchdog counter width: $clog2(TIMEOUT+1).

## Test plan
- Single request: req_valid=4'b0010, op=ADD, a=8'h12, b=8'h34, ALU done 3 cycles after start with result 8'h46 → req_ready=4'b0010 at accept; alu_start one pulse at t+1 with alu_a=12, alu_b=34; resp_valid=4'b0010, resp_data=8'h46, resp_err=0.
- Round robin: all four requesters valid continuously → grant order 0,1,2,3,0. No requester is granted twice before the others.
- Timeout: TIMEOUT=16, alu_done held 0 → resp_valid[owner] with resp_err=1 and resp_data=0, 17 cycles after alu_start. ptr advances.
- Back-pressure: resp_ready held 0 for 10 cycles → resp_valid/resp_data stable, req_ready stays 0 for other requesters. Release → IDLE next cycle.
- Spurious and simultaneous events:
  - alu_done in IDLE/ISSUE → ignored.
  - alu_done on the timeout cycle → normal result, err=0.
- Reset mid-WAIT: rst for 1 cycle → all outputs 0, ptr=0, and no response issued for the dropped op.
